rob_dispatch_unit: RTL and testbench

//  Transmitter side of the ROB dispatch interface. Accepts decoded instructions from the decode stage,

---
 rtl/rob_dispatch_unit_pkg.sv | 22 ++
 rtl/rob_dispatch_unit_if.sv | 30 +++
 rtl/rob_dispatch_unit_dispatch_queue.sv | 96 +++++++++
 rtl/rob_dispatch_unit.sv | 117 +++++++++++
 tb/tb_rob_dispatch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_dispatch_unit_pkg.sv
// Widths shared with the reorder buffer, the packed queue entry and the head state encoding
// used by the ROB dispatch unit.
package rob_dispatch_unit_pkg;
   localparam int NUM_GENERAL_PURPOSE_REGISTER        = 32;
   localparam int ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS  = 6;
   localparam int ROB_DST_WIDTH_IN_BITS               = $clog2(NUM_GENERAL_PURPOSE_REGISTER);
   localparam int ROB_ADDRESS_WIDTH_IN_BITS           = 32;
   localparam int DEFAULT_QUEUE_DEPTH                 = 4;
   localparam int DEFAULT_STALL_COUNTER_WIDTH_IN_BITS = 16;
   localparam int DISPATCHED_COUNTER_WIDTH_IN_BITS    = 32;

   typedef struct packed {
      logic [ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS-1:0] instruction_type;
      logic [ROB_DST_WIDTH_IN_BITS-1:0]              dst;
      logic [ROB_ADDRESS_WIDTH_IN_BITS-1:0]          address;
   } dispatch_entry_t;

   typedef enum logic [0:0] {
      HEAD_EMPTY   = 1'b0,
      HEAD_PRESENT = 1'b1
   } head_state_t;
endpackage

// File: rtl/rob_dispatch_unit_if.sv
// Decode-side and ROB-side handshake bundle of the dispatch unit.
// The slave modport is the dispatch unit's view; master is the surrounding pipeline.
interface rob_dispatch_unit_if;
   import rob_dispatch_unit_pkg::*;

   logic                                          decode_valid_in;
   logic                                          decode_ready_out;
   logic [ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS-1:0] decode_instruction_type_in;
   logic [ROB_DST_WIDTH_IN_BITS-1:0]              decode_dst_in;
   logic [ROB_ADDRESS_WIDTH_IN_BITS-1:0]          decode_address_in;
   logic                                          dispatch_valid_out;
   logic [ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS-1:0] dispatch_instruction_type_out;
   logic [ROB_DST_WIDTH_IN_BITS-1:0]              dispatch_dst_out;
   logic [ROB_ADDRESS_WIDTH_IN_BITS-1:0]          dispatch_address_out;
   logic                                          issue_ack_in;

   modport slave (
      input  decode_valid_in, decode_instruction_type_in, decode_dst_in, decode_address_in,
      input  issue_ack_in,
      output decode_ready_out,
      output dispatch_valid_out, dispatch_instruction_type_out, dispatch_dst_out, dispatch_address_out
   );

   modport master (
      output decode_valid_in, decode_instruction_type_in, decode_dst_in, decode_address_in,
      output issue_ack_in,
      input  decode_ready_out,
      input  dispatch_valid_out, dispatch_instruction_type_out, dispatch_dst_out, dispatch_address_out
   );
endinterface

// File: rtl/rob_dispatch_unit_dispatch_queue.sv
// In-order instruction FIFO with flush. The head entry and the ready flag are registered
// from next-state values so nothing on the write side reaches the read side combinationally.
module dispatch_queue
   import rob_dispatch_unit_pkg::*;
#(
   parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  dispatch_entry_t          wr_entry,
   output dispatch_entry_t          head_entry,
   output logic                     ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   dispatch_entry_t   mem_r [DEPTH];
   dispatch_entry_t   head_r;
   dispatch_entry_t   head_next_s;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_next_s;
   logic [PTR_W-1:0]  rd_ptr_next_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic              ready_r;
   logic              do_push_s;
   logic              do_pop_s;

   // Next pointers and count; flush overrides any push or pop
   always_comb begin
      do_push_s     = 1'b0;
      do_pop_s      = 1'b0;
      wr_ptr_next_s = wr_ptr_r;
      rd_ptr_next_s = rd_ptr_r;
      count_next_s  = count_r;
      head_next_s   = head_r;
      if (flush) begin
         wr_ptr_next_s = PTR_ZERO;
         rd_ptr_next_s = PTR_ZERO;
         count_next_s  = CNT_ZERO;
      end else begin
         do_push_s     = push && (count_r != CNT_FULL);
         do_pop_s      = pop && (count_r != CNT_ZERO);
         wr_ptr_next_s = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
         rd_ptr_next_s = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
         case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
         endcase
      end
      // The entry being written becomes the head when it lands on the new read slot
      if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_next_s = wr_entry;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // Storage, pointers, count and the registered head/ready views
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         head_r   <= '0;
         ready_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_entry;
         end
         wr_ptr_r <= wr_ptr_next_s;
         rd_ptr_r <= rd_ptr_next_s;
         count_r  <= count_next_s;
         head_r   <= head_next_s;
         ready_r  <= (count_next_s != CNT_FULL);
      end
   end

   assign head_entry = head_r;
   assign ready      = ready_r;
   assign count      = count_r;
endmodule

// File: rtl/rob_dispatch_unit.sv
// Transmitter side of the ROB dispatch interface: queues decoded instructions, presents the head
// to the reorder buffer until acknowledged, and keeps stall and dispatch counters.
module rob_dispatch_unit
   import rob_dispatch_unit_pkg::*;
#(
   parameter int QUEUE_DEPTH                 = DEFAULT_QUEUE_DEPTH,
   parameter int STALL_COUNTER_WIDTH_IN_BITS = DEFAULT_STALL_COUNTER_WIDTH_IN_BITS
) (
   input  logic                                        clk_in,
   input  logic                                        reset_in,
   rob_dispatch_unit_if.slave                          rob_if,
   input  logic                                        flush_in,
   output logic [STALL_COUNTER_WIDTH_IN_BITS-1:0]      stall_cycle_count_out,
   output logic [DISPATCHED_COUNTER_WIDTH_IN_BITS-1:0] dispatched_count_out
);
   localparam int SW    = STALL_COUNTER_WIDTH_IN_BITS;
   localparam int DW    = DISPATCHED_COUNTER_WIDTH_IN_BITS;
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [SW-1:0]    STALL_ONE  = SW'(1);
   localparam logic [SW-1:0]    STALL_ZERO = SW'(0);
   localparam logic [SW-1:0]    STALL_MAX  = {SW{1'b1}};
   localparam logic [DW-1:0]    DISP_ONE   = DW'(1);
   localparam logic [DW-1:0]    DISP_ZERO  = DW'(0);

   head_state_t      state_r;
   logic             valid_r;
   logic             ready_s;
   logic             push_s;
   logic             pop_s;
   logic             stall_s;
   logic [CNT_W-1:0] count_s;
   dispatch_entry_t  wr_entry_s;
   dispatch_entry_t  head_s;
   logic [SW-1:0]    stall_count_r;
   logic [DW-1:0]    dispatched_count_r;

   // Handshake qualification: an ack only counts while an entry is presented
   always_comb begin
      wr_entry_s.instruction_type = rob_if.decode_instruction_type_in;
      wr_entry_s.dst              = rob_if.decode_dst_in;
      wr_entry_s.address          = rob_if.decode_address_in;
      push_s  = rob_if.decode_valid_in && ready_s;
      pop_s   = valid_r && rob_if.issue_ack_in;
      stall_s = valid_r && !rob_if.issue_ack_in;
   end

   dispatch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk_in),
      .reset      (reset_in),
      .flush      (flush_in),
      .push       (push_s),
      .pop        (pop_s),
      .wr_entry   (wr_entry_s),
      .head_entry (head_s),
      .ready      (ready_s),
      .count      (count_s)
   );

   // Head state machine; dispatch valid is its registered output
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_r <= HEAD_EMPTY;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            HEAD_EMPTY: begin
               if (!flush_in && push_s) begin
                  state_r <= HEAD_PRESENT;
                  valid_r <= 1'b1;
               end else begin
                  state_r <= HEAD_EMPTY;
                  valid_r <= 1'b0;
               end
            end
            HEAD_PRESENT: begin
               if (flush_in || (pop_s && (count_s == CNT_ONE) && !push_s)) begin
                  state_r <= HEAD_EMPTY;
                  valid_r <= 1'b0;
               end else begin
                  state_r <= HEAD_PRESENT;
                  valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= HEAD_EMPTY;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Stall and throughput counters survive a flush; only reset clears them
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         stall_count_r      <= STALL_ZERO;
         dispatched_count_r <= DISP_ZERO;
      end else begin
         if (stall_s && (stall_count_r != STALL_MAX)) begin
            stall_count_r <= stall_count_r + STALL_ONE;
         end
         if (pop_s) begin
            dispatched_count_r <= dispatched_count_r + DISP_ONE;
         end
      end
   end

   assign rob_if.decode_ready_out              = ready_s;
   assign rob_if.dispatch_valid_out            = valid_r;
   assign rob_if.dispatch_instruction_type_out = head_s.instruction_type;
   assign rob_if.dispatch_dst_out              = head_s.dst;
   assign rob_if.dispatch_address_out          = head_s.address;
   assign stall_cycle_count_out                = stall_count_r;
   assign dispatched_count_out                 = dispatched_count_r;
endmodule

// File: tb/tb_rob_dispatch_unit.sv
// Self-checking bench for rob_dispatch_unit: a queue-based reference model tracks what the
// ROB should see, and each scenario task compares the DUT against it after every clock edge.
module tb_rob_dispatch_unit;
   import rob_dispatch_unit_pkg::*;

   localparam int DEPTH = 4;

   logic        clk_in;
   logic        reset_in;
   logic        flush_in;
   logic [15:0] stall_cycle_count_out;
   logic [31:0] dispatched_count_out;

   rob_dispatch_unit_if bus ();

   rob_dispatch_unit #(
      .QUEUE_DEPTH                 (DEPTH),
      .STALL_COUNTER_WIDTH_IN_BITS (16)
   ) dut (
      .clk_in                (clk_in),
      .reset_in              (reset_in),
      .rob_if                (bus),
      .flush_in              (flush_in),
      .stall_cycle_count_out (stall_cycle_count_out),
      .dispatched_count_out  (dispatched_count_out)
   );

   logic [42:0] model_q [$];
   logic [15:0] model_stall;
   logic [31:0] model_disp;
   int          n_checks;
   int          n_errors;

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   function automatic logic [42:0] rand_entry();
      logic [42:0] e;
      e[31:0]  = $urandom;
      e[42:32] = 11'($urandom);
      return e;
   endfunction

   task automatic set_decode(input logic valid, input logic [42:0] e);
      bus.decode_valid_in            = valid;
      bus.decode_instruction_type_in = e[42:37];
      bus.decode_dst_in              = e[36:32];
      bus.decode_address_in          = e[31:0];
   endtask

   function automatic logic [42:0] observed_entry();
      return {bus.dispatch_instruction_type_out, bus.dispatch_dst_out, bus.dispatch_address_out};
   endfunction

   // One clock edge: the model applies the transfer rules to the pre-edge inputs, then settles #1
   task automatic cycle(output bit accepted);
      bit          m_valid, m_ready, m_push, m_pop;
      logic [42:0] in_e;
      m_valid = (model_q.size() != 0);
      m_ready = (model_q.size() != DEPTH);
      m_push  = bus.decode_valid_in && m_ready;
      m_pop   = m_valid && bus.issue_ack_in;
      in_e    = {bus.decode_instruction_type_in, bus.decode_dst_in, bus.decode_address_in};
      @(posedge clk_in);
      accepted = 1'b0;
      if (reset_in) begin
         model_q.delete();
         model_stall = 16'h0000;
         model_disp  = 32'h0;
      end else begin
         if (m_valid && !bus.issue_ack_in && model_stall != 16'hFFFF) model_stall = model_stall + 16'd1;
         if (m_pop) model_disp = model_disp + 32'd1;
         if (flush_in) begin
            model_q.delete();
         end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
               model_q.push_back(in_e);
               accepted = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      bit acc;
      reset_in = 1'b1;
      set_decode(1'b1, rand_entry());
      bus.issue_ack_in = 1'b0;
      flush_in = 1'b0;
      for (int i = 0; i < 3; i++) cycle(acc);
      n_checks++; if (bus.dispatch_valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.dispatch_valid_out); end
      n_checks++; if (observed_entry() !== 43'h0) begin n_errors++; $display("FAIL reset_payload: got %h expected 0", observed_entry()); end
      reset_in = 1'b0;
      set_decode(1'b0, 43'h0);
      cycle(acc);
      n_checks++; if (bus.dispatch_valid_out !== 1'b0) begin n_errors++; $display("FAIL release_valid: got %b expected 0", bus.dispatch_valid_out); end
      n_checks++; if (bus.decode_ready_out !== 1'b1) begin n_errors++; $display("FAIL release_ready: got %b expected 1", bus.decode_ready_out); end
      n_checks++; if (stall_cycle_count_out !== 16'h0) begin n_errors++; $display("FAIL release_stall: got %h expected 0", stall_cycle_count_out); end
      n_checks++; if (dispatched_count_out !== 32'h0) begin n_errors++; $display("FAIL release_disp: got %h expected 0", dispatched_count_out); end
   endtask

   task automatic test_single_dispatch();
      bit          acc;
      logic [42:0] e;
      e = {6'h05, 5'd7, 32'h0000_1000};
      set_decode(1'b1, e);
      bus.issue_ack_in = 1'b1;
      cycle(acc);
      set_decode(1'b0, 43'h0);
      n_checks++; if (bus.dispatch_valid_out !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", bus.dispatch_valid_out); end
      n_checks++; if (observed_entry() !== e) begin n_errors++; $display("FAIL single_payload: got %h expected %h", observed_entry(), e); end
      cycle(acc);
      n_checks++; if (dispatched_count_out !== 32'd1) begin n_errors++; $display("FAIL single_disp: got %0d expected 1", dispatched_count_out); end
      n_checks++; if (bus.dispatch_valid_out !== 1'b0) begin n_errors++; $display("FAIL single_drained: got %b expected 0", bus.dispatch_valid_out); end
   endtask

   task automatic test_fill_stall();
      bit          acc;
      logic [42:0] e [5];
      int          idx;
      for (int i = 0; i < 5; i++) e[i] = rand_entry();
      idx = 0;
      bus.issue_ack_in = 1'b0;
      set_decode(1'b1, e[0]);
      for (int c = 0; c < 7; c++) begin
         cycle(acc);
         if (acc) begin
            idx++;
            if (idx < 5) set_decode(1'b1, e[idx]);
         end
         n_checks++; if (bus.decode_ready_out !== (model_q.size() != DEPTH)) begin n_errors++; $display("FAIL fill_ready c%0d: got %b expected %b", c, bus.decode_ready_out, model_q.size() != DEPTH); end
         n_checks++; if (observed_entry() !== e[0]) begin n_errors++; $display("FAIL fill_head c%0d: got %h expected %h", c, observed_entry(), e[0]); end
         n_checks++; if (stall_cycle_count_out !== model_stall) begin n_errors++; $display("FAIL fill_stall c%0d: got %0d expected %0d", c, stall_cycle_count_out, model_stall); end
      end
      n_checks++; if (idx !== 4) begin n_errors++; $display("FAIL fill_accepted: got %0d expected 4", idx); end
   endtask

   task automatic test_wrap_drain();
      bit acc;
      bus.issue_ack_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle(acc);
         if (acc) set_decode(1'b1, rand_entry());
         n_checks++; if (bus.dispatch_valid_out !== 1'b1 || observed_entry() !== model_q[0]) begin n_errors++; $display("FAIL wrap_head c%0d: got %b/%h expected 1/%h", c, bus.dispatch_valid_out, observed_entry(), model_q[0]); end
      end
      set_decode(1'b0, 43'h0);
      for (int c = 0; c < 10 && model_q.size() != 0; c++) begin
         cycle(acc);
         if (model_q.size() != 0) begin
            n_checks++; if (observed_entry() !== model_q[0]) begin n_errors++; $display("FAIL drain_head c%0d: got %h expected %h", c, observed_entry(), model_q[0]); end
         end
      end
      n_checks++; if (bus.dispatch_valid_out !== 1'b0 || model_q.size() != 0) begin n_errors++; $display("FAIL drain_empty: got valid %b model size %0d expected 0", bus.dispatch_valid_out, model_q.size()); end
      n_checks++; if (dispatched_count_out !== model_disp) begin n_errors++; $display("FAIL drain_disp: got %0d expected %0d", dispatched_count_out, model_disp); end
   endtask

   task automatic test_flush();
      bit          acc;
      logic [31:0] disp_before;
      bus.issue_ack_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_decode(1'b1, rand_entry());
         cycle(acc);
      end
      disp_before = dispatched_count_out;
      flush_in = 1'b1;
      bus.issue_ack_in = 1'b1;
      set_decode(1'b1, rand_entry());
      cycle(acc);
      flush_in = 1'b0;
      bus.issue_ack_in = 1'b0;
      set_decode(1'b0, 43'h0);
      n_checks++; if (bus.dispatch_valid_out !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", bus.dispatch_valid_out); end
      n_checks++; if (bus.decode_ready_out !== 1'b1) begin n_errors++; $display("FAIL flush_ready: got %b expected 1", bus.decode_ready_out); end
      n_checks++; if (dispatched_count_out !== disp_before + 32'd1) begin n_errors++; $display("FAIL flush_disp: got %0d expected %0d", dispatched_count_out, disp_before + 32'd1); end
      cycle(acc);
      n_checks++; if (bus.dispatch_valid_out !== 1'b0) begin n_errors++; $display("FAIL flush_push_dropped: got %b expected 0", bus.dispatch_valid_out); end
   endtask

   task automatic test_stall_saturate();
      bit acc;
      bus.issue_ack_in = 1'b0;
      set_decode(1'b1, rand_entry());
      cycle(acc);
      set_decode(1'b0, 43'h0);
      force dut.stall_count_r = 16'hFFFE;
      #1;
      release dut.stall_count_r;
      model_stall = 16'hFFFE;
      n_checks++; if (stall_cycle_count_out !== 16'hFFFE) begin n_errors++; $display("FAIL sat_preload: got %h expected fffe", stall_cycle_count_out); end
      for (int c = 0; c < 3; c++) begin
         cycle(acc);
         n_checks++; if (stall_cycle_count_out !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold c%0d: got %h expected ffff", c, stall_cycle_count_out); end
      end
      bus.issue_ack_in = 1'b1;
      cycle(acc);
      bus.issue_ack_in = 1'b0;
   endtask

   task automatic test_random();
      bit acc;
      reset_in = 1'b1;
      cycle(acc);
      reset_in = 1'b0;
      for (int c = 0; c < 300; c++) begin
         set_decode(($urandom_range(0, 9) < 7), rand_entry());
         bus.issue_ack_in = $urandom_range(0, 1);
         flush_in = ($urandom_range(0, 19) == 0);
         cycle(acc);
         n_checks++; if (bus.dispatch_valid_out !== (model_q.size() != 0)) begin n_errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, bus.dispatch_valid_out, model_q.size() != 0); end
         n_checks++; if (bus.decode_ready_out !== (model_q.size() != DEPTH)) begin n_errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.decode_ready_out, model_q.size() != DEPTH); end
         if (model_q.size() != 0) begin
            n_checks++; if (observed_entry() !== model_q[0]) begin n_errors++; $display("FAIL rand_head c%0d: got %h expected %h", c, observed_entry(), model_q[0]); end
         end
         n_checks++; if (stall_cycle_count_out !== model_stall) begin n_errors++; $display("FAIL rand_stall c%0d: got %0d expected %0d", c, stall_cycle_count_out, model_stall); end
         n_checks++; if (dispatched_count_out !== model_disp) begin n_errors++; $display("FAIL rand_disp c%0d: got %0d expected %0d", c, dispatched_count_out, model_disp); end
      end
      flush_in = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      model_stall = 16'h0;
      model_disp  = 32'h0;
      reset_in    = 1'b1;
      flush_in    = 1'b0;
      bus.issue_ack_in = 1'b0;
      set_decode(1'b0, 43'h0);
      test_reset();
      test_single_dispatch();
      test_fill_stall();
      test_wrap_drain();
      test_flush();
      test_stall_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
